// File: rtl/hud_pkg.sv
// Shared types and constants for the HUD strip renderer: colour type,
// FSM state encoding, default palette and the heart icon bitmap.
package hud_pkg;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } hud_state_t;

  localparam colour_t DEF_BG_COLOUR    = 3'b000;
  localparam colour_t DEF_FULL_COLOUR  = 3'b100;
  localparam colour_t DEF_EMPTY_COLOUR = 3'b111;
  localparam colour_t BORDER_COLOUR    = 3'b110;

  // 8x8 heart. Row v occupies bits [v*8+7 : v*8]; column u=0 is the
  // leftmost pixel and sits in the row's MSB, so pixel (u,v) is bit {v,~u}.
  localparam logic [63:0] HEART_BITMAP = {
    8'h00,  // row 7
    8'h18,  // row 6
    8'h3C,  // row 5
    8'h7E,  // row 4
    8'hFF,  // row 3
    8'hFF,  // row 2
    8'hFF,  // row 1
    8'h66   // row 0
  };

endpackage

// File: rtl/hud_renderer_if.sv
// Control handshake plus VGA write port of the HUD renderer.
// master = control/VGA side, slave = the renderer itself.
interface hud_renderer_if #(
  parameter int HW = 4
) ();

  logic          enable;
  logic          draw_ack;
  logic [HW-1:0] health;
  logic [8:0]    x_pos;
  logic [7:0]    y_pos;
  logic [2:0]    colour;
  logic          VGA_write;
  logic          draw_done;

  modport master (
    output enable, draw_ack, health,
    input  x_pos, y_pos, colour, VGA_write, draw_done
  );

  modport slave (
    input  enable, draw_ack, health,
    output x_pos, y_pos, colour, VGA_write, draw_done
  );

endinterface

// File: rtl/hud_icon_rom.sv
// Combinational icon bitmap lookup. Swap this module for different icon art.
module hud_icon_rom
  import hud_pkg::*;
(
  input  logic [2:0] u,
  input  logic [2:0] v,
  output logic       pixel
);

  assign pixel = HEART_BITMAP[{v, ~u}];

endmodule

// File: rtl/hud_renderer.sv
// HUD strip rasteriser: draws background plus a row of health hearts into
// VGA memory, one pixel per clock, sequenced by enable/draw_done/draw_ack.
// Optional build macro HUD_BORDER_EN paints a one-pixel frame around the strip.
module hud_renderer
  import hud_pkg::*;
#(
  parameter int      HUD_X0       = 0,
  parameter int      HUD_Y0       = 0,
  parameter int      HUD_W        = 320,
  parameter int      HUD_H        = 16,
  parameter int      NUM_ICONS    = 8,
  parameter int      ICON_W       = 8,
  parameter int      ICON_H       = 8,
  parameter int      ICON_X       = 4,
  parameter int      ICON_Y       = 4,
  parameter int      ICON_GAP     = 2,
  parameter colour_t BG_COLOUR    = DEF_BG_COLOUR,
  parameter colour_t FULL_COLOUR  = DEF_FULL_COLOUR,
  parameter colour_t EMPTY_COLOUR = DEF_EMPTY_COLOUR
) (
  input  logic         clock,
  input  logic         reset,
  hud_renderer_if.slave bus
);

  localparam int HW = $clog2(NUM_ICONS + 1);

  localparam logic [8:0] W_LAST     = 9'(HUD_W - 1);
  localparam logic [7:0] H_LAST     = 8'(HUD_H - 1);
  localparam logic [8:0] PITCH_LAST = 9'(ICON_W + ICON_GAP - 1);
  localparam logic [8:0] IX         = 9'(ICON_X);
  localparam logic [7:0] IY         = 8'(ICON_Y);
  localparam logic [8:0] IY_END     = 9'(ICON_Y + ICON_H);

  // Reject strips that would fall off the 320x240 screen.
  generate
    if ((HUD_W < 1) || (HUD_H < 1) ||
        (HUD_X0 + HUD_W > 320) || (HUD_Y0 + HUD_H > 240)) begin : g_bad_geometry
      $error("hud_renderer: HUD rectangle does not fit on a 320x240 screen");
    end
  endgenerate

  hud_state_t    state_reg;
  logic [8:0]    cx_reg;
  logic [7:0]    cy_reg;
  logic [8:0]    u_reg;      // column inside the current icon slot
  logic [8:0]    k_reg;      // current icon slot index
  logic [HW-1:0] h_lat_reg;

  logic [8:0]    x_pos_reg;
  logic [7:0]    y_pos_reg;
  colour_t       colour_reg;
  logic          vga_write_reg;
  logic          draw_done_reg;

  logic [HW-1:0] health_clamped;
  logic [2:0]    v_off;
  logic          rom_pixel;
  logic          in_rows;
  logic          in_cols;
  colour_t       pix_colour;
  colour_t       colour_next;
  logic          last_col;
  logic          last_px;

  hud_icon_rom u_icon_rom (
    .u     (u_reg[2:0]),
    .v     (v_off),
    .pixel (rom_pixel)
  );

  // Saturate the incoming health at the number of slots.
  always_comb begin
    health_clamped = bus.health;
    if (bus.health > HW'(NUM_ICONS)) health_clamped = HW'(NUM_ICONS);
  end

  // Pixel colour for the current (cx,cy) using the running slot counters.
  always_comb begin
    v_off      = 3'(cy_reg - IY);
    in_rows    = (cy_reg >= IY) && ({1'b0, cy_reg} < IY_END);
    in_cols    = (cx_reg >= IX) && (k_reg < 9'(NUM_ICONS)) && (u_reg < 9'(ICON_W));
    pix_colour = BG_COLOUR;
    if (in_rows && in_cols && rom_pixel) begin
      pix_colour = (k_reg < 9'(h_lat_reg)) ? FULL_COLOUR : EMPTY_COLOUR;
    end
`ifdef HUD_BORDER_EN
    if ((cx_reg == 9'd0) || (cx_reg == W_LAST) ||
        (cy_reg == 8'd0) || (cy_reg == H_LAST)) begin
      colour_next = BORDER_COLOUR;
    end else begin
      colour_next = pix_colour;
    end
`else
    colour_next = pix_colour;
`endif
    last_col = (cx_reg == W_LAST);
    last_px  = last_col && (cy_reg == H_LAST);
  end

  // Control FSM with raster counters and registered VGA outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cx_reg        <= '0;
      cy_reg        <= '0;
      u_reg         <= '0;
      k_reg         <= '0;
      h_lat_reg     <= '0;
      x_pos_reg     <= '0;
      y_pos_reg     <= '0;
      colour_reg    <= '0;
      vga_write_reg <= 1'b0;
      draw_done_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          vga_write_reg <= 1'b0;
          draw_done_reg <= 1'b0;
          if (bus.enable) begin
            h_lat_reg <= health_clamped;
            cx_reg    <= '0;
            cy_reg    <= '0;
            u_reg     <= '0;
            k_reg     <= '0;
            state_reg <= DRAW;
          end
        end
        DRAW: begin
          draw_done_reg <= 1'b0;
          if (!bus.enable) begin
            // Abort: stop writing at once and wait for a fresh request.
            vga_write_reg <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            x_pos_reg     <= 9'(HUD_X0) + cx_reg;
            y_pos_reg     <= 8'(HUD_Y0) + cy_reg;
            colour_reg    <= colour_next;
            vga_write_reg <= 1'b1;
            if (last_col) begin
              cx_reg <= '0;
              cy_reg <= cy_reg + 8'd1;
              u_reg  <= '0;
              k_reg  <= '0;
            end else begin
              cx_reg <= cx_reg + 9'd1;
              // Slot counters start moving once the icon row begins.
              if (cx_reg >= IX) begin
                if (u_reg == PITCH_LAST) begin
                  u_reg <= '0;
                  k_reg <= k_reg + 9'd1;
                end else begin
                  u_reg <= u_reg + 9'd1;
                end
              end
            end
            if (last_px) state_reg <= DONE;
          end
        end
        DONE: begin
          vga_write_reg <= 1'b0;
          if (bus.draw_ack) begin
            draw_done_reg <= 1'b0;
            state_reg     <= IDLE;
          end else begin
            draw_done_reg <= 1'b1;
          end
        end
        default: begin
          vga_write_reg <= 1'b0;
          draw_done_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.x_pos     = x_pos_reg;
  assign bus.y_pos     = y_pos_reg;
  assign bus.colour    = colour_reg;
  assign bus.VGA_write = vga_write_reg;
  assign bus.draw_done = draw_done_reg;

endmodule

// File: tb/tb_hud_renderer.sv
// Directed bench for hud_renderer: a reference model queues every expected
// write, a monitor pops and compares each VGA write as it appears.
module tb_hud_renderer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hud_renderer_if #(.HW(4)) bus ();
  hud_renderer_if #(.HW(4)) bus2 ();

  hud_renderer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  hud_renderer #(
    .HUD_X0 (10),
    .HUD_Y0 (20),
    .HUD_W  (40),
    .HUD_H  (10)
  ) dut_small (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  int checks   = 0;
  int failures = 0;
  int writes   = 0;
  int writes2  = 0;
  logic [19:0] exp_q[$];
  logic [2:0]  c_a = 3'bxxx;
  logic [2:0]  c_b = 3'bxxx;
  logic [2:0]  c_c = 3'bxxx;

  logic [7:0] heart [8] = '{8'h66, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00};

  // Reference pixel for default icon geometry (x4, y4, 8x8, pitch 10, 8 slots).
  function automatic logic [2:0] model_pix(input int cx, input int cy, input int h);
    int k;
    int u;
    logic [7:0] row;
    model_pix = 3'b000;
    if (cy >= 4 && cy < 12 && cx >= 4) begin
      k   = (cx - 4) / 10;
      u   = (cx - 4) % 10;
      row = heart[cy - 4];
      if (k < 8 && u < 8) begin
        if (row[7 - u]) model_pix = (k < h) ? 3'b100 : 3'b111;
      end
    end
  endfunction

  task automatic push_frame(input int h);
    int hc;
    hc = (h > 8) ? 8 : h;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 320; x++)
        exp_q.push_back({9'(x), 8'(y), model_pix(x, y, hc)});
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic wait_done(input string tag, input int want_cyc);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (bus.draw_done !== 1'b1 && cyc < 6000);
    chk({tag, "_done_cycle"}, cyc, want_cyc);
    chk({tag, "_write_at_done"}, 32'(bus.VGA_write), 0);
  endtask

  // Scoreboard monitor for the default-geometry instance.
  always @(negedge clock) begin
    logic [19:0] got_t;
    logic [19:0] exp_t;
    if (bus.VGA_write === 1'b1) begin
      got_t = {bus.x_pos, bus.y_pos, bus.colour};
      exp_t = 20'hFFFFF;
      if (exp_q.size() > 0) exp_t = exp_q.pop_front();
      writes++;
      checks++;
      assert (got_t === exp_t) else begin
        failures++;
        $error("FAIL pixel: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
               got_t[19:11], got_t[10:3], got_t[2:0],
               exp_t[19:11], exp_t[10:3], exp_t[2:0]);
      end
    end
  end

  // Capture monitor for the small bordered-geometry instance.
  always @(negedge clock) begin
    if (bus2.VGA_write === 1'b1) begin
      writes2++;
      if (bus2.x_pos == 9'd10 && bus2.y_pos == 8'd20) c_a = bus2.colour;
      if (bus2.x_pos == 9'd49 && bus2.y_pos == 8'd29) c_b = bus2.colour;
      if (bus2.x_pos == 9'd10 && bus2.y_pos == 8'd25) c_c = bus2.colour;
    end
  end

  initial begin
    int cyc;
    logic done_seen;
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.draw_ack  = 1'b0;
    bus.health    = '0;
    bus2.enable   = 1'b0;
    bus2.draw_ack = 1'b0;
    bus2.health   = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_x", 32'(bus.x_pos), 0);
    chk("rst_y", 32'(bus.y_pos), 0);
    chk("rst_colour", 32'(bus.colour), 0);
    chk("rst_write", 32'(bus.VGA_write), 0);
    chk("rst_done", 32'(bus.draw_done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Frame 1: health 3, enable held
    writes = 0;
    push_frame(3);
    bus.health = 4'd3;
    bus.enable = 1'b1;
    wait_done("f1", 5122);
    chk("f1_writes", writes, 5120);
    chk("f1_queue", exp_q.size(), 0);
    $display("TXN frame1 health=3 writes=%0d", writes);

    // draw_done holds until ack; next frame uses health 15 (clamped to 8)
    bus.health = 4'd15;
    push_frame(15);
    repeat (10) @(negedge clock);
    chk("done_held", 32'(bus.draw_done), 1);
    bus.draw_ack = 1'b1;
    @(negedge clock);
    chk("done_drop", 32'(bus.draw_done), 0);
    bus.draw_ack = 1'b0;
    writes = 0;
    repeat (50) @(negedge clock);
    bus.health = 4'd0;  // must be ignored mid-frame
    wait_done("f2", 5072);
    chk("f2_writes", writes, 5120);
    chk("f2_queue", exp_q.size(), 0);
    $display("TXN frame2 health=15 writes=%0d", writes);

    // Ack while dropping enable: return to idle with no restart
    bus.draw_ack = 1'b1;
    bus.enable   = 1'b0;
    @(negedge clock);
    bus.draw_ack = 1'b0;
    chk("ack_idle_done", 32'(bus.draw_done), 0);
    repeat (3) @(negedge clock);
    chk("idle_no_write", 32'(bus.VGA_write), 0);

    // Abort after 100 writes
    writes = 0;
    push_frame(5);
    bus.health = 4'd5;
    bus.enable = 1'b1;
    repeat (101) @(negedge clock);
    bus.enable = 1'b0;
    @(negedge clock);
    chk("abort_write", 32'(bus.VGA_write), 0);
    done_seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (bus.draw_done === 1'b1) done_seen = 1'b1;
    end
    chk("abort_no_done", 32'(done_seen), 0);
    chk("abort_writes", writes, 100);
    chk("abort_queue", exp_q.size(), 5020);
    exp_q.delete();
    $display("TXN abort writes=%0d", writes);

    // Re-enable restarts from (0,0)
    writes = 0;
    push_frame(5);
    bus.enable = 1'b1;
    wait_done("restart", 5122);
    chk("restart_writes", writes, 5120);
    chk("restart_queue", exp_q.size(), 0);
    $display("TXN restart health=5 writes=%0d", writes);

    // Ack with enable held: a new frame starts, then reset mid-frame
    push_frame(5);
    bus.draw_ack = 1'b1;
    @(negedge clock);
    bus.draw_ack = 1'b0;
    chk("ack2_done", 32'(bus.draw_done), 0);
    repeat (60) @(negedge clock);
    chk("pre_reset_write", 32'(bus.VGA_write), 1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_x", 32'(bus.x_pos), 0);
    chk("async_y", 32'(bus.y_pos), 0);
    chk("async_colour", 32'(bus.colour), 0);
    chk("async_write", 32'(bus.VGA_write), 0);
    chk("async_done", 32'(bus.draw_done), 0);
    exp_q.delete();
    @(negedge clock);
    writes = 0;
    push_frame(2);
    bus.health = 4'd2;
    reset = 1'b1;
    wait_done("post_reset", 5122);
    chk("post_reset_writes", writes, 5120);
    chk("post_reset_queue", exp_q.size(), 0);
    $display("TXN post_reset health=2 writes=%0d", writes);
    bus.draw_ack = 1'b1;
    bus.enable   = 1'b0;
    @(negedge clock);
    bus.draw_ack = 1'b0;

    // Small offset strip (40x10 at 10,20), health 0
    writes2 = 0;
    bus2.enable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (bus2.draw_done !== 1'b1 && cyc < 1000);
    chk("small_done_cycle", cyc, 402);
    chk("small_writes", writes2, 400);
`ifdef HUD_BORDER_EN
    chk("small_10_20", 32'(c_a), 32'(3'b110));
    chk("small_49_29", 32'(c_b), 32'(3'b110));
    chk("small_10_25", 32'(c_c), 32'(3'b110));
`else
    chk("small_10_20", 32'(c_a), 32'(model_pix(0, 0, 0)));
    chk("small_49_29", 32'(c_b), 32'(model_pix(39, 9, 0)));
    chk("small_10_25", 32'(c_c), 32'(model_pix(0, 5, 0)));
`endif
    $display("TXN small_strip writes=%0d", writes2);
    bus2.draw_ack = 1'b1;
    bus2.enable   = 1'b0;
    @(negedge clock);
    bus2.draw_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
